// File: rtl/matvec_pkg.sv
// Shared definitions for the matrix-vector sequencer:
// CPU and engine register maps, engine command codes, FSM states.
package matvec_pkg;

    localparam logic [5:0] R_CTRL     = 6'h00;
    localparam logic [5:0] R_LENGTH   = 6'h01;
    localparam logic [5:0] R_NUM_ROWS = 6'h02;
    localparam logic [5:0] R_ADDR_MAT = 6'h03;
    localparam logic [5:0] R_STRIDE   = 6'h04;
    localparam logic [5:0] R_ADDR_VEC = 6'h05;
    localparam logic [5:0] R_ROW_IDX  = 6'h06;
    localparam logic [5:0] R_SAT      = 6'h07;
    localparam logic [5:0] R_RES_IDX  = 6'h08;
    localparam logic [5:0] R_RES_DATA = 6'h09;

    localparam logic [7:0] E_CTRL   = 8'h00;
    localparam logic [7:0] E_LENGTH = 8'h04;
    localparam logic [7:0] E_RES_LO = 8'h08;
    localparam logic [7:0] E_RES_HI = 8'h0C;
    localparam logic [7:0] E_ADDR_A = 8'h10;
    localparam logic [7:0] E_ADDR_B = 8'h14;

    localparam logic [31:0] CTRL_PRELOAD = 32'd5;
    localparam logic [31:0] CTRL_CACHED  = 32'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_LEN,
        S_WR_VEC,
        S_WR_PRE,
        S_POLL_B,
        S_WR_ROW,
        S_WR_GO,
        S_POLL_ROW,
        S_RD_LO,
        S_RD_HI,
        S_STORE,
        S_NEXT,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/dp_reg_master.sv
// One-shot engine register access: a held request becomes a single
// dp_valid pulse, always followed by at least one idle cycle.
module dp_reg_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        write_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        dp_valid_o,
    output logic        dp_write_o,
    output logic [7:0]  dp_addr_o,
    output logic [31:0] dp_wdata_o,
    input  logic [31:0] dp_rdata_i,
    input  logic        dp_ready_i,
    output logic        done_o,
    output logic [31:0] rdata_o
);

    logic        valid_q;
    logic        write_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic        launch;

    // The pulse cycle itself blocks a relaunch, which yields the gap.
    assign launch = req_i && !valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= launch;
            write_q <= launch && write_i;
            addr_q  <= launch ? addr_i : '0;
            wdata_q <= launch ? wdata_i : '0;
        end
    end

    assign dp_valid_o = valid_q;
    assign dp_write_o = write_q;
    assign dp_addr_o  = addr_q;
    assign dp_wdata_o = wdata_q;
    assign done_o     = valid_q && dp_ready_i;
    assign rdata_o    = dp_rdata_i;

endmodule

// File: rtl/matvec_sequencer.sv
// Runs y = M*x on the dot-product engine one row at a time and keeps
// the rescaled Q16.16 results in a local result RAM.
module matvec_sequencer
    import matvec_pkg::*;
#(
    parameter int MAX_ROWS   = 64,
    parameter int MAX_LENGTH = 512,
    parameter int FRAC_SHIFT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_valid,
    input  logic        reg_write,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ready,
    output logic        dp_valid,
    output logic        dp_write,
    output logic [7:0]  dp_addr,
    output logic [31:0] dp_wdata,
    input  logic [31:0] dp_rdata,
    input  logic        dp_ready
);

    localparam int IW = $clog2(MAX_ROWS);

    state_e      state_q, state_d;
    logic        acc_q;
    logic [9:0]  len_q;
    logic [31:0] rows_q;
    logic [23:0] mat_q, stride_q, vec_q, row_addr_q;
    logic [31:0] row_idx_q, sat_q, lo_q, hi_q;
    logic [IW-1:0] res_idx_q;
    logic        abort_q, started_q, done_q, aborted_q, err_q;
    logic [31:0] ram_q [MAX_ROWS];

    logic        busy, wr_fire, rd_fire, cfg_bad, start_ok;
    logic        abort_go, more_rows;
    logic [5:0]  widx;
    logic        req, req_wr;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata, dp_rd;
    logic        dp_done;
    logic        unused_ok;

    logic signed [63:0] acc_s, shr_s;
    logic        sat_hi, sat_lo;
    logic [31:0] res_val;

    assign widx      = reg_addr[7:2];
    assign unused_ok = ^reg_addr[1:0];
    assign reg_ready = reg_valid;
    assign busy      = (state_q != S_IDLE);
    assign wr_fire   = reg_valid && reg_write && !acc_q;
    assign rd_fire   = reg_valid && !reg_write && !acc_q
                       && (widx == R_RES_DATA);

    assign cfg_bad = (len_q == '0)
                  || ({22'd0, len_q} > 32'(MAX_LENGTH))
                  || (rows_q == '0)
                  || (rows_q > 32'(MAX_ROWS));

    assign start_ok = wr_fire && (widx == R_CTRL) && !busy
                      && reg_wdata[0] && !reg_wdata[1] && !cfg_bad;

    assign more_rows = (row_idx_q + 32'd1) < rows_q;

    // Abort takes effect only between accesses, never mid-pulse.
    assign abort_go = abort_q && busy && (state_q != S_DRAIN) && !dp_valid;

    assign acc_s  = {hi_q, lo_q};
    assign shr_s  = acc_s >>> FRAC_SHIFT;
    assign sat_hi = !shr_s[63] && (|shr_s[62:31]);
    assign sat_lo = shr_s[63] && !(&shr_s[62:31]);
    assign res_val = sat_hi ? 32'h7FFF_FFFF :
                     sat_lo ? 32'h8000_0000 : shr_s[31:0];

    dp_reg_master u_master (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .write_i    (req_wr),
        .addr_i     (req_addr),
        .wdata_i    (req_wdata),
        .dp_valid_o (dp_valid),
        .dp_write_o (dp_write),
        .dp_addr_o  (dp_addr),
        .dp_wdata_o (dp_wdata),
        .dp_rdata_i (dp_rdata),
        .dp_ready_i (dp_ready),
        .done_o     (dp_done),
        .rdata_o    (dp_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        req_wr    = 1'b0;
        req_addr  = E_CTRL;
        req_wdata = '0;
        unique case (state_q)
            S_IDLE: if (start_ok) state_d = S_WR_LEN;
            S_WR_LEN: begin
                req = 1'b1; req_wr = 1'b1;
                req_addr = E_LENGTH; req_wdata = {22'd0, len_q};
                if (dp_done) state_d = S_WR_VEC;
            end
            S_WR_VEC: begin
                req = 1'b1; req_wr = 1'b1;
                req_addr = E_ADDR_B; req_wdata = {8'd0, vec_q};
                if (dp_done) state_d = S_WR_PRE;
            end
            S_WR_PRE: begin
                req = 1'b1; req_wr = 1'b1; req_wdata = CTRL_PRELOAD;
                if (dp_done) state_d = S_POLL_B;
            end
            S_POLL_B: begin
                req = 1'b1;
                if (dp_done && !dp_rd[0]) state_d = S_WR_ROW;
            end
            S_WR_ROW: begin
                req = 1'b1; req_wr = 1'b1;
                req_addr = E_ADDR_A; req_wdata = {8'd0, row_addr_q};
                if (dp_done) state_d = S_WR_GO;
            end
            S_WR_GO: begin
                req = 1'b1; req_wr = 1'b1; req_wdata = CTRL_CACHED;
                if (dp_done) state_d = S_POLL_ROW;
            end
            S_POLL_ROW: begin
                req = 1'b1;
                if (dp_done && !dp_rd[0]) state_d = S_RD_LO;
            end
            S_RD_LO: begin
                req = 1'b1; req_addr = E_RES_LO;
                if (dp_done) state_d = S_RD_HI;
            end
            S_RD_HI: begin
                req = 1'b1; req_addr = E_RES_HI;
                if (dp_done) state_d = S_STORE;
            end
            S_STORE: state_d = S_NEXT;
            S_NEXT:  state_d = more_rows ? S_WR_ROW : S_IDLE;
            S_DRAIN: begin
                req = 1'b1;
                if (dp_done && !dp_rd[0]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_go) begin
            req     = 1'b0;
            state_d = started_q ? S_DRAIN : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= 1'b0;
            len_q      <= '0;
            rows_q     <= '0;
            mat_q      <= '0;
            stride_q   <= '0;
            vec_q      <= '0;
            row_addr_q <= '0;
            row_idx_q  <= '0;
            sat_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            res_idx_q  <= '0;
            abort_q    <= 1'b0;
            started_q  <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            acc_q <= reg_valid;
            if (wr_fire) begin
                case (widx)
                    R_CTRL: begin
                        if (busy && reg_wdata[1])
                            abort_q <= 1'b1;
                        else if (!busy && reg_wdata[0] && !reg_wdata[1] && cfg_bad)
                            err_q <= 1'b1;
                    end
                    R_LENGTH:   if (!busy) len_q    <= reg_wdata[9:0];
                    R_NUM_ROWS: if (!busy) rows_q   <= reg_wdata;
                    R_ADDR_MAT: if (!busy) mat_q    <= reg_wdata[23:0];
                    R_STRIDE:   if (!busy) stride_q <= reg_wdata[23:0];
                    R_ADDR_VEC: if (!busy) vec_q    <= reg_wdata[23:0];
                    R_RES_IDX:  res_idx_q <= reg_wdata[IW-1:0];
                    default: ;
                endcase
            end
            if (start_ok) begin
                done_q     <= 1'b0;
                aborted_q  <= 1'b0;
                err_q      <= 1'b0;
                row_idx_q  <= '0;
                sat_q      <= '0;
                row_addr_q <= mat_q;
                started_q  <= 1'b0;
            end
            if (rd_fire) res_idx_q <= res_idx_q + IW'(1);
            if (state_q == S_RD_LO && dp_done) lo_q <= dp_rd;
            if (state_q == S_RD_HI && dp_done) hi_q <= dp_rd;
            if ((state_q == S_WR_PRE || state_q == S_WR_GO) && dp_done)
                started_q <= 1'b1;
            if (state_q == S_STORE && !abort_q && (sat_hi || sat_lo)
                && sat_q != '1)
                sat_q <= sat_q + 32'd1;
            if (state_q == S_NEXT && !abort_q) begin
                row_idx_q  <= row_idx_q + 32'd1;
                row_addr_q <= row_addr_q + stride_q;
                if (!more_rows) done_q <= 1'b1;
            end
            if (busy && state_d == S_IDLE) begin
                abort_q <= 1'b0;
                if (abort_q) aborted_q <= 1'b1;
            end
        end
    end

    // Result RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (state_q == S_STORE && !abort_q)
            ram_q[row_idx_q[IW-1:0]] <= res_val;
    end

    always_comb begin
        reg_rdata = '0;
        case (widx)
            R_CTRL:     reg_rdata = {28'd0, err_q, aborted_q, done_q, busy};
            R_LENGTH:   reg_rdata = {22'd0, len_q};
            R_NUM_ROWS: reg_rdata = rows_q;
            R_ADDR_MAT: reg_rdata = {8'd0, mat_q};
            R_STRIDE:   reg_rdata = {8'd0, stride_q};
            R_ADDR_VEC: reg_rdata = {8'd0, vec_q};
            R_ROW_IDX:  reg_rdata = row_idx_q;
            R_SAT:      reg_rdata = sat_q;
            R_RES_IDX:  reg_rdata = 32'(res_idx_q);
            R_RES_DATA: reg_rdata = ram_q[res_idx_q];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer with a small behavioural
// dot-product engine that logs every register access.
module tb_matvec_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_valid = 1'b0;
    logic        reg_write = 1'b0;
    logic [7:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        reg_ready;
    logic        dp_valid, dp_write, dp_ready;
    logic [7:0]  dp_addr;
    logic [31:0] dp_wdata, dp_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] A_CTRL = 8'h00, A_LEN = 8'h04, A_ROWS = 8'h08;
    localparam logic [7:0] A_MAT = 8'h0C, A_STRIDE = 8'h10, A_VEC = 8'h14;
    localparam logic [7:0] A_ROWIDX = 8'h18, A_SAT = 8'h1C;
    localparam logic [7:0] A_RESIDX = 8'h20, A_RESDATA = 8'h24;

    matvec_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .reg_valid (reg_valid),
        .reg_write (reg_write),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready),
        .dp_valid  (dp_valid),
        .dp_write  (dp_write),
        .dp_addr   (dp_addr),
        .dp_wdata  (dp_wdata),
        .dp_rdata  (dp_rdata),
        .dp_ready  (dp_ready)
    );

    always #5 clk = ~clk;

    // Engine model: CTRL reads report busy for busy_set polls after
    // each CTRL write; results come from acc_tab[ADDR_A[4:2]].
    logic [63:0] acc_tab [8];
    logic [23:0] addr_a_m = '0;
    int          busy_cnt = 0;
    int          busy_set = 1;
    int          go_seen = 0;
    int          adj_err = 0;
    logic        prev_v = 1'b0;
    logic        log_w [$];
    logic [7:0]  log_a [$];
    logic [31:0] log_d [$];

    assign dp_ready = dp_valid;

    always_comb begin
        dp_rdata = '0;
        case (dp_addr)
            8'h00: dp_rdata = {31'd0, busy_cnt != 0};
            8'h08: dp_rdata = acc_tab[addr_a_m[4:2]][31:0];
            8'h0C: dp_rdata = acc_tab[addr_a_m[4:2]][63:32];
            default: ;
        endcase
    end

    always @(posedge clk) begin
        prev_v <= dp_valid;
        if (dp_valid && prev_v) adj_err <= adj_err + 1;
        if (dp_valid) begin
            log_w.push_back(dp_write);
            log_a.push_back(dp_addr);
            log_d.push_back(dp_wdata);
            if (dp_write) begin
                if (dp_addr == 8'h00) begin
                    busy_cnt <= busy_set;
                    if (dp_wdata == 32'd3) go_seen <= go_seen + 1;
                end
                if (dp_addr == 8'h10) addr_a_m <= dp_wdata[23:0];
            end else if (dp_addr == 8'h00 && busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_valid = 1'b0; reg_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a;
        #1 d = reg_rdata;
        @(negedge clk);
        reg_valid = 1'b0;
    endtask

    task automatic configure(input int len, input int rows,
                             input logic [31:0] mat, input logic [31:0] stride,
                             input logic [31:0] vec);
        cpu_write(A_LEN, 32'(len));
        cpu_write(A_ROWS, 32'(rows));
        cpu_write(A_MAT, mat);
        cpu_write(A_STRIDE, stride);
        cpu_write(A_VEC, vec);
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        int n = 0;
        do begin
            cpu_read(A_CTRL, s);
            n++;
        end while (s[0] && n < 1000);
        checks++;
        if (s[0]) begin
            errors++;
            $display("FAIL %s_idle: busy=%0d after %0d polls, required 0", name, s[0], n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] s;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dp_valid, dp_write, dp_addr, dp_wdata} !== 42'd0) begin
            errors++;
            $display("FAIL reset_dp: got v=%0d w=%0d a=%h d=%h, required all 0",
                     dp_valid, dp_write, dp_addr, dp_wdata);
        end
        reset = 1'b0;
        cpu_read(A_CTRL, s);
        checks++;
        if (s !== 32'h0) begin
            errors++; $display("FAIL reset_status: got %h, required 0", s);
        end
        cpu_read(A_LEN, s);
        checks++;
        if (s !== 32'h0) begin
            errors++; $display("FAIL reset_length: got %h, required 0", s);
        end
        cpu_read(A_ROWIDX, s);
        checks++;
        if (s !== 32'h0) begin
            errors++; $display("FAIL reset_row_idx: got %h, required 0", s);
        end
    endtask

    task automatic test_basic();
        logic [31:0] s;
        acc_tab[0] = 64'h0;
        acc_tab[1] = 64'h1_0000_0000;
        acc_tab[2] = 64'h2_0000_0000;
        busy_set = 1;
        configure(4, 3, 32'h0, 32'h4, 32'h100);
        cpu_write(A_CTRL, 32'h1);
        wait_idle("basic");
        cpu_read(A_CTRL, s);
        checks++;
        if (s !== 32'h2) begin
            errors++; $display("FAIL basic_status: got %h, required 2", s);
        end
        cpu_read(A_ROWIDX, s);
        checks++;
        if (s !== 32'd3) begin
            errors++; $display("FAIL basic_row_idx: got %0d, required 3", s);
        end
        cpu_write(A_RESIDX, 32'h0);
        for (int r = 0; r < 3; r++) begin
            cpu_read(A_RESDATA, s);
            checks++;
            if (s !== 32'(r) * 32'h10000) begin
                errors++;
                $display("FAIL basic_res%0d: got %h, required %h", r, s, 32'(r) * 32'h10000);
            end
        end
        cpu_read(A_RESIDX, s);
        checks++;
        if (s !== 32'd3) begin
            errors++; $display("FAIL basic_res_idx: got %0d, required 3", s);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] s;
        logic [31:0] exp_r [3];
        acc_tab[0] = 64'h0001_0000_0000_0000;
        acc_tab[1] = 64'hFFFF_0000_0000_0000;
        acc_tab[2] = 64'hFFFF_FFFF_FFFF_0000;
        exp_r[0] = 32'h7FFF_FFFF;
        exp_r[1] = 32'h8000_0000;
        exp_r[2] = 32'hFFFF_FFFF;
        busy_set = 2;
        configure(16, 3, 32'h0, 32'h4, 32'h200);
        cpu_write(A_CTRL, 32'h1);
        wait_idle("sat");
        cpu_read(A_SAT, s);
        checks++;
        if (s !== 32'd2) begin
            errors++; $display("FAIL sat_count: got %0d, required 2", s);
        end
        cpu_write(A_RESIDX, 32'h0);
        for (int r = 0; r < 3; r++) begin
            cpu_read(A_RESDATA, s);
            checks++;
            if (s !== exp_r[r]) begin
                errors++;
                $display("FAIL sat_res%0d: got %h, required %h", r, s, exp_r[r]);
            end
        end
    endtask

    task automatic test_protocol();
        logic [40:0] exp_q [$];
        logic [40:0] got;
        int base;
        busy_set = 5;
        acc_tab[0] = 64'h0;
        exp_q.push_back({1'b1, 8'h04, 32'd8});
        exp_q.push_back({1'b1, 8'h14, 32'h300});
        exp_q.push_back({1'b1, 8'h00, 32'd5});
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'h00, 32'd0});
        exp_q.push_back({1'b1, 8'h10, 32'h40});
        exp_q.push_back({1'b1, 8'h00, 32'd3});
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'h00, 32'd0});
        exp_q.push_back({1'b0, 8'h08, 32'd0});
        exp_q.push_back({1'b0, 8'h0C, 32'd0});
        configure(8, 1, 32'h40, 32'h8, 32'h300);
        base = log_a.size();
        cpu_write(A_CTRL, 32'h1);
        wait_idle("proto");
        checks++;
        if (log_a.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL proto_count: got %0d accesses, required %0d",
                     log_a.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                got = {log_w[base+i], log_a[base+i],
                       log_w[base+i] ? log_d[base+i] : 32'd0};
                checks++;
                if (got !== exp_q[i]) begin
                    errors++;
                    $display("FAIL proto_acc%0d: got %h, required %h", i, got, exp_q[i]);
                end
            end
        end
        checks++;
        if (adj_err != 0) begin
            errors++; $display("FAIL proto_gap: got %0d adjacent pulses, required 0", adj_err);
        end
    endtask

    task automatic test_abort();
        logic [31:0] s;
        int g0, idx, n, wr_after;
        busy_set = 4;
        configure(4, 3, 32'h0, 32'h4, 32'h100);
        g0 = go_seen;
        cpu_write(A_CTRL, 32'h1);
        n = 0;
        while (go_seen < g0 + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (go_seen < g0 + 2) begin
            errors++; $display("FAIL abort_wait_go: got %0d row starts, required 2", go_seen - g0);
        end
        idx = log_a.size();
        cpu_write(A_CTRL, 32'h2);
        wait_idle("abort");
        cpu_read(A_CTRL, s);
        checks++;
        if (s !== 32'h4) begin
            errors++; $display("FAIL abort_status: got %h, required 4", s);
        end
        cpu_read(A_ROWIDX, s);
        checks++;
        if (s !== 32'd1) begin
            errors++; $display("FAIL abort_row_idx: got %0d, required 1", s);
        end
        wr_after = 0;
        for (int i = idx; i < log_a.size(); i++) if (log_w[i]) wr_after++;
        checks++;
        if (wr_after != 0) begin
            errors++; $display("FAIL abort_writes: got %0d writes after abort, required 0", wr_after);
        end
        checks++;
        if (busy_cnt != 0) begin
            errors++; $display("FAIL abort_drain: engine busy count %0d, required 0", busy_cnt);
        end
    endtask

    task automatic test_errors();
        logic [31:0] s;
        int lens [4];
        int rows [4];
        int n0;
        lens[0] = 0;   rows[0] = 3;
        lens[1] = 4;   rows[1] = 0;
        lens[2] = 4;   rows[2] = 65;
        lens[3] = 513; rows[3] = 1;
        busy_set = 0;
        for (int c = 0; c < 4; c++) begin
            configure(1, 1, 32'h0, 32'h4, 32'h0);
            cpu_write(A_CTRL, 32'h1);
            wait_idle("err_prep");
            configure(lens[c], rows[c], 32'h0, 32'h4, 32'h0);
            n0 = log_a.size();
            cpu_write(A_CTRL, 32'h1);
            repeat (4) @(negedge clk);
            cpu_read(A_CTRL, s);
            checks++;
            if ({s[3], s[0]} !== 2'b10) begin
                errors++;
                $display("FAIL err_case%0d: got err=%0d busy=%0d, required err=1 busy=0", c, s[3], s[0]);
            end
            checks++;
            if (log_a.size() != n0) begin
                errors++;
                $display("FAIL err_dp%0d: got %0d accesses, required 0", c, log_a.size() - n0);
            end
        end
        configure(512, 64, 32'h0, 32'h4, 32'h0);
        cpu_write(A_CTRL, 32'h1);
        cpu_read(A_CTRL, s);
        checks++;
        if ({s[3], s[0]} !== 2'b01) begin
            errors++;
            $display("FAIL err_bound: got err=%0d busy=%0d, required err=0 busy=1", s[3], s[0]);
        end
        cpu_write(A_CTRL, 32'h2);
        wait_idle("err_bound");
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        int n;
        busy_set = 2;
        acc_tab[0] = 64'h1_0000_0000;
        acc_tab[1] = 64'h2_0000_0000;
        configure(4, 2, 32'h0, 32'h4, 32'h0);
        cpu_write(A_CTRL, 32'h1);
        n = 0;
        @(negedge clk);
        while (!(dp_valid && dp_write && dp_addr == 8'h00 && dp_wdata == 32'd3)
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++; $display("FAIL rst_mid_wait: no WR_GO pulse seen, required one");
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({dp_valid, dp_write, dp_addr, dp_wdata} !== 42'd0) begin
            errors++;
            $display("FAIL rst_mid_dp: got v=%0d w=%0d a=%h d=%h, required all 0",
                     dp_valid, dp_write, dp_addr, dp_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        cpu_read(A_CTRL, s);
        checks++;
        if (s !== 32'h0) begin
            errors++; $display("FAIL rst_mid_status: got %h, required 0", s);
        end
        configure(4, 2, 32'h0, 32'h4, 32'h0);
        cpu_write(A_CTRL, 32'h1);
        wait_idle("rst_mid");
        cpu_read(A_CTRL, s);
        checks++;
        if (s !== 32'h2) begin
            errors++; $display("FAIL rst_mid_done: got %h, required 2", s);
        end
        cpu_write(A_RESIDX, 32'h0);
        for (int r = 0; r < 2; r++) begin
            cpu_read(A_RESDATA, s);
            checks++;
            if (s !== 32'(r + 1) * 32'h10000) begin
                errors++;
                $display("FAIL rst_mid_res%0d: got %h, required %h", r, s, 32'(r + 1) * 32'h10000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_protocol();
        test_abort();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
